nway_cache_array: RTL
=====================

NWAY_CACHE_ARRAY -- requirements
Module: nway_cache_array

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  ADDRESS_WORD_SIZE, 32, address width
  TAG_SIZE, 19, tag bits
  NUMBER_OF_SETS, 128, sets (power of 2)
  WAYS, 4, ways per set (power of 2, >=2)
  BLOCK_SIZE, 16, words per line
  WORD_SIZE, 4, bytes per word
REQ-002 Derived widths SHALL be:
  IDX = log2(NUMBER_OF_SETS); OFF = log2(BLOCK_SIZE*WORD_SIZE); AW = log2(WAYS).
  TAG_SIZE+IDX+OFF SHALL equal ADDRESS_WORD_SIZE (elaboration error otherwise).
REQ-003 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  clock, single domain
  rst_b  in  1  asynchronous active-low reset
  req_valid  in  1  request present
  req_ready  out  1  request accepted when high with req_valid
  req_op  in  2  00 READ, 01 WRITE, 10 ALLOC, 11 FLUSH
  address_word  in  ADDRESS_WORD_SIZE  tag | index | byte offset
  write_data  in  8  byte for WRITE
  resp_valid  out  1  response present
  resp_ready  in  1  response consumed
  hit_miss  out  1  1 = tag hit
  hit_miss_set  out  WAYS  one-hot hit / allocated way
  data  out  8  read byte
  ages  out  WAYS*AW  ages of the set after update, way 0 in LSBs
  victim_dirty  out  1  ALLOC evicted a valid dirty line
  victim_tag  out  TAG_SIZE  tag of evicted line

Function
REQ-004 FSM states SHALL be IDLE, LOOKUP, RESP, FLUSH; req_ready=1 only in IDLE.
REQ-005 Accept in IDLE: latch op/address/write_data, go LOOKUP (non-FLUSH) or FLUSH.
REQ-006 LOOKUP (one cycle): compare tag against all valid ways of indexed set; update state; register outputs; go RESP.
REQ-007 RESP: resp_valid=1, outputs stable until resp_valid&&resp_ready, then IDLE; min request-to-response latency 2 cycles.
REQ-008 READ hit: data = addressed byte, hit_miss=1, hit_miss_set = way; miss: hit_miss=0, hit_miss_set=0, data=0x00, no state change.
REQ-009 WRITE hit: store byte, set dirty; WRITE miss: no allocation, no state change (write-no-allocate).
REQ-010 ALLOC: victim = lowest-index invalid way, else way with age WAYS-1; install tag, valid=1, dirty=0, all line bytes 0x00; hit_miss=0, hit_miss_set = victim one-hot, victim_dirty/victim_tag from the old line (victim_dirty=0 if old line invalid).
REQ-011 ALLOC of a tag already present SHALL behave as READ hit (no duplicate tags).
REQ-012 LRU on hit or ALLOC of way w with old age a: age[w]=0; every way with age<a increments; others unchanged; ages stay a permutation of 0..WAYS-1.
REQ-013 Misses (READ/WRITE) SHALL NOT change ages.
REQ-014 FLUSH: clear valid and dirty of one set per cycle, index 0 upward, NUMBER_OF_SETS cycles, then RESP with hit_miss=0, hit_miss_set=0; ages reset to way index.
REQ-015 req_valid during non-IDLE SHALL be ignored (held off by req_ready=0).

Reset
REQ-016 rst_b low SHALL asynchronously: state=IDLE, all valid/dirty=0, age[w]=w in every set, all outputs 0 except req_ready=1.
REQ-017 Reset mid-LOOKUP/RESP/FLUSH SHALL abort without partial update surviving; data bytes and tags need not reset.

Structure
REQ-018 Op encodings, FSM state type and a clog2 function SHALL live in shared package cache_pkg.
REQ-019 Age update logic SHALL be sub-module lru_age_update (inputs: ages, accessed way; output: new ages).

Verification
REQ-020 Reset, READ 0x0000_1040 -> 2 cycles later resp_valid, hit_miss=0, ages=0xE4 (WAYS=4).
REQ-021 ALLOC 0x0000_1040 then WRITE 0xA5 at 0x0000_1043, READ 0x0000_1043 -> hit, hit_miss_set=0001, data=0xA5, age[0]=0.
REQ-022 Five ALLOCs, distinct tags, same set -> fifth evicts first tag, victim_dirty=1 if it was written.
REQ-023 Hold resp_ready=0 for 5 cycles -> outputs stable, req_ready=0, new req_valid ignored.
REQ-024 FLUSH -> response after NUMBER_OF_SETS+1 cycles; subsequent READ of prior hit -> miss.
REQ-025 Assert rst_b during FLUSH at set 40 -> all sets invalid, req_ready=1 immediately.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache array.
// Holds request opcodes, controller state type and a constant clog2 helper
// used to derive index/offset/age widths at elaboration.
package cache_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ALLOC = 2'b10,
        OP_FLUSH = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOOKUP = 2'b01,
        ST_RESP   = 2'b10,
        ST_FLUSH  = 2'b11
    } state_e;

    // Ceiling log2 usable in parameter expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lru_age_update.sv
// Age-based LRU update for one set.
// Ports: i_ages  - current ages, way 0 in LSBs (AW bits per way)
//        i_way   - way being accessed / installed
//        o_ages  - ages after the access
// Accessed way becomes 0; every way younger than its old age ages by one.
module lru_age_update #(
    parameter int WAYS = 4,
    parameter int AW   = 2
) (
    input  logic [WAYS*AW-1:0] i_ages,
    input  logic [AW-1:0]      i_way,
    output logic [WAYS*AW-1:0] o_ages
);

    logic [AW-1:0] w_old;
    assign w_old = i_ages[i_way*AW +: AW];

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic [AW-1:0] w_cur;
        assign w_cur = i_ages[g*AW +: AW];
        assign o_ages[g*AW +: AW] = (AW'(g) == i_way) ? '0 :
                                    (w_cur < w_old)   ? w_cur + AW'(1) : w_cur;
    end

endmodule

// File: rtl/nway_cache_array.sv
// N-way set-associative cache tag/data array with age-based LRU.
// Ports: clk/rst_b (async active-low); request channel req_valid/req_ready
//        with req_op, address_word, write_data; response channel
//        resp_valid/resp_ready with hit_miss, hit_miss_set (one-hot way),
//        data (byte), ages (set ages after update), victim_dirty/victim_tag.
// One request in flight: IDLE accepts, LOOKUP does the whole access in one
// cycle, RESP holds registered results until consumed. FLUSH walks sets.
module nway_cache_array
    import cache_pkg::*;
#(
    parameter int ADDRESS_WORD_SIZE = 32,
    parameter int TAG_SIZE          = 19,
    parameter int NUMBER_OF_SETS    = 128,
    parameter int WAYS              = 4,
    parameter int BLOCK_SIZE        = 16,
    parameter int WORD_SIZE         = 4,
    localparam int AW               = clog2(WAYS)
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [ADDRESS_WORD_SIZE-1:0] address_word,
    input  logic [7:0]                   write_data,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         hit_miss,
    output logic [WAYS-1:0]              hit_miss_set,
    output logic [7:0]                   data,
    output logic [WAYS*AW-1:0]           ages,
    output logic                         victim_dirty,
    output logic [TAG_SIZE-1:0]          victim_tag
);

    localparam int IDX        = clog2(NUMBER_OF_SETS);
    localparam int LINE_BYTES = BLOCK_SIZE * WORD_SIZE;
    localparam int OFF        = clog2(LINE_BYTES);

    if (TAG_SIZE + IDX + OFF != ADDRESS_WORD_SIZE) begin : g_bad_geometry
        $error("nway_cache_array: TAG_SIZE+IDX+OFF must equal ADDRESS_WORD_SIZE");
    end

    // Control / request latch
    state_e                         r_state, w_next;
    op_e                            r_op;
    logic [ADDRESS_WORD_SIZE-1:0]   r_addr;
    logic [7:0]                     r_wdata;
    logic [IDX-1:0]                 r_flush_idx;

    // State that must come up clean on reset
    logic [NUMBER_OF_SETS-1:0][WAYS-1:0]    r_valid;
    logic [NUMBER_OF_SETS-1:0][WAYS-1:0]    r_dirty;
    logic [NUMBER_OF_SETS-1:0][WAYS*AW-1:0] r_age;

    // Payload arrays; meaningless while the matching valid bit is clear
    logic [TAG_SIZE-1:0]     r_tag  [NUMBER_OF_SETS][WAYS];
    logic [LINE_BYTES*8-1:0] r_line [NUMBER_OF_SETS][WAYS];

    // Registered response
    logic                r_hit_miss, r_vdirty;
    logic [WAYS-1:0]     r_set;
    logic [7:0]          r_data;
    logic [WAYS*AW-1:0]  r_ages_o;
    logic [TAG_SIZE-1:0] r_vtag;

    // Lookup datapath
    logic [TAG_SIZE-1:0] w_tag;
    logic [IDX-1:0]      w_idx;
    logic [OFF-1:0]      w_off;
    logic [WAYS-1:0]     w_hit_vec;
    logic                w_hit, w_any_inv;
    logic [AW-1:0]       w_hit_way, w_inv_way, w_lru_way, w_vic_way, w_acc_way;
    logic [WAYS*AW-1:0]  w_age_init, w_new_ages;
    logic [7:0]          w_rd_byte;
    logic                w_flush_last;

    assign w_tag = r_addr[ADDRESS_WORD_SIZE-1 -: TAG_SIZE];
    assign w_idx = r_addr[OFF +: IDX];
    assign w_off = r_addr[OFF-1:0];

    for (genvar g = 0; g < WAYS; g++) begin : g_age_init
        assign w_age_init[g*AW +: AW] = AW'(g);
    end

    always_comb begin
        w_hit_vec = '0;
        w_hit_way = '0;
        w_inv_way = '0;
        w_lru_way = '0;
        w_any_inv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
            if (w_hit_vec[w]) w_hit_way = AW'(w);
            if (r_age[w_idx][w*AW +: AW] == AW'(WAYS-1)) w_lru_way = AW'(w);
        end
        // Scan downward so the lowest-index invalid way wins.
        for (int w = WAYS-1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_any_inv = 1'b1;
                w_inv_way = AW'(w);
            end
        end
    end

    assign w_hit        = |w_hit_vec;
    assign w_vic_way    = w_any_inv ? w_inv_way : w_lru_way;
    assign w_acc_way    = w_hit ? w_hit_way : w_vic_way;
    assign w_rd_byte    = r_line[w_idx][w_hit_way][{w_off, 3'b000} +: 8];
    assign w_flush_last = (r_flush_idx == IDX'(NUMBER_OF_SETS-1));

    lru_age_update #(.WAYS(WAYS), .AW(AW)) u_lru (
        .i_ages (r_age[w_idx]),
        .i_way  (w_acc_way),
        .o_ages (w_new_ages)
    );

    // FSM
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_next = (req_op == OP_FLUSH) ? ST_FLUSH : ST_LOOKUP;
            ST_LOOKUP: w_next = ST_RESP;
            ST_FLUSH:  if (w_flush_last) w_next = ST_RESP;
            ST_RESP:   if (resp_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Request latch and flush walker
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_op        <= OP_READ;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_flush_idx <= '0;
        end else if (r_state == ST_IDLE && req_valid) begin
            r_op        <= op_e'(req_op);
            r_addr      <= address_word;
            r_wdata     <= write_data;
            r_flush_idx <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_flush_idx <= r_flush_idx + IDX'(1);
        end
    end

    // Valid/dirty/age state and response registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_valid    <= '0;
            r_dirty    <= '0;
            r_age      <= {NUMBER_OF_SETS{w_age_init}};
            r_hit_miss <= 1'b0;
            r_set      <= '0;
            r_data     <= '0;
            r_ages_o   <= '0;
            r_vdirty   <= 1'b0;
            r_vtag     <= '0;
        end else if (r_state == ST_LOOKUP) begin
            r_hit_miss <= w_hit;
            r_set      <= '0;
            r_data     <= '0;
            r_vdirty   <= 1'b0;
            r_vtag     <= '0;
            r_ages_o   <= r_age[w_idx];
            if (w_hit) begin
                // ALLOC of a resident tag degenerates to a read hit.
                r_set         <= WAYS'(1) << w_hit_way;
                r_age[w_idx]  <= w_new_ages;
                r_ages_o      <= w_new_ages;
                if (r_op == OP_WRITE) r_dirty[w_idx][w_hit_way] <= 1'b1;
                else                  r_data <= w_rd_byte;
            end else if (r_op == OP_ALLOC) begin
                r_set                      <= WAYS'(1) << w_vic_way;
                r_age[w_idx]               <= w_new_ages;
                r_ages_o                   <= w_new_ages;
                r_valid[w_idx][w_vic_way]  <= 1'b1;
                r_dirty[w_idx][w_vic_way]  <= 1'b0;
                r_vdirty <= r_valid[w_idx][w_vic_way] && r_dirty[w_idx][w_vic_way];
                r_vtag   <= r_valid[w_idx][w_vic_way] ? r_tag[w_idx][w_vic_way] : '0;
            end
        end else if (r_state == ST_FLUSH) begin
            r_valid[r_flush_idx] <= '0;
            r_dirty[r_flush_idx] <= '0;
            r_age[r_flush_idx]   <= w_age_init;
            if (w_flush_last) begin
                r_hit_miss <= 1'b0;
                r_set      <= '0;
                r_data     <= '0;
                r_ages_o   <= w_age_init;
                r_vdirty   <= 1'b0;
                r_vtag     <= '0;
            end
        end
    end

    // Tag and line storage (no reset: guarded by valid bits)
    always_ff @(posedge clk) begin
        if (r_state == ST_LOOKUP) begin
            if (r_op == OP_WRITE && w_hit)
                r_line[w_idx][w_hit_way][{w_off, 3'b000} +: 8] <= r_wdata;
            if (r_op == OP_ALLOC && !w_hit) begin
                r_tag[w_idx][w_vic_way]  <= w_tag;
                r_line[w_idx][w_vic_way] <= '0;
            end
        end
    end

    assign req_ready    = (r_state == ST_IDLE);
    assign resp_valid   = (r_state == ST_RESP);
    assign hit_miss     = r_hit_miss;
    assign hit_miss_set = r_set;
    assign data         = r_data;
    assign ages         = r_ages_o;
    assign victim_dirty = r_vdirty;
    assign victim_tag   = r_vtag;

endmodule
